// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dp_pkg
// Brief    : Shared constants and types for the datapath operand driver.
// Revision : 1.0  initial release
// ============================================================================
package dp_pkg;

  // Default operand width of the attached datapath
  localparam int DP_DATAW = 8;

  // Deepest datapath register latency the driver is built to track
  localparam int LAT_MAX = 4;

  // One captured datapath result: combinational z and registered x
  typedef struct packed {
    logic [DP_DATAW-1:0]   z;
    logic [2*DP_DATAW-1:0] x;
  } dp_result_t;

  // One signed operand triple as presented by the host
  typedef struct packed {
    logic [DP_DATAW-1:0] a;
    logic [DP_DATAW-1:0] b;
    logic [DP_DATAW-1:0] c;
  } dp_operands_t;

endpackage
`default_nettype wire

// File: rtl/dp_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dp_sync_fifo
// Brief    : Synchronous first-word-fall-through FIFO with occupancy count.
//            The head entry is visible on head whenever empty is low.
// Revision : 1.0  initial release
// ============================================================================
module dp_sync_fifo
  import dp_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 3 * DP_DATAW,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_full    = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  // A push into a full FIFO is only legal when the head leaves the same cycle
  assign w_push_ok = push && (!w_full || pop);
  assign w_pop_ok  = pop && !empty;
  assign head      = r_mem[r_rptr];
  assign count     = r_count;

  // Storage, pointers (wrap naturally at the power-of-two depth) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop_ok) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dp_operand_driver.sv
`default_nettype none
// ============================================================================
// Module   : dp_operand_driver
// Brief    : Host front end for a generated datapath. Registers operand
//            triples onto dp_a/b/c, follows each one through the datapath
//            latency with a valid-tag shift register, captures the aligned
//            {z, x} pair into a result FIFO and returns results in order.
//            Optional: DP_SELF_CHECK_EN adds a sticky chk_err output that
//            flags any captured x not matching a*c - (a+b).
// Revision : 1.0  initial release
// ============================================================================
module dp_operand_driver
  import dp_pkg::*;
#(
  parameter int DATAW      = DP_DATAW,
  parameter int LAT        = 1,
  parameter int RESQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATAW-1:0]   in_a,
  input  logic [DATAW-1:0]   in_b,
  input  logic [DATAW-1:0]   in_c,
  output logic [DATAW-1:0]   dp_a,
  output logic [DATAW-1:0]   dp_b,
  output logic [DATAW-1:0]   dp_c,
  input  logic [DATAW-1:0]   dp_z,
  input  logic [2*DATAW-1:0] dp_x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATAW-1:0]   out_z,
  output logic [2*DATAW-1:0] out_x,
  output logic               busy
`ifdef DP_SELF_CHECK_EN
  ,
  output logic               chk_err
`endif
);

  localparam int c_RW  = 3 * DATAW;                 // {z, x}
  localparam int c_FCW = $clog2(RESQ_DEPTH) + 1;    // FIFO count width
  localparam int c_IFW = $clog2(LAT_MAX + 2);       // up to LAT+1 in flight
  localparam int c_SW  = c_FCW + c_IFW;             // reserved-slot sum

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [c_FCW-1:0]  w_fifo_count;
  logic [c_RW-1:0]   w_head;
  logic [c_SW-1:0]   w_reserved;
  logic              r_init;
  logic [LAT:0]      r_tag;
  logic [c_IFW-1:0]  r_inflight;
  logic [DATAW-1:0]  r_zpipe [1:LAT];
  logic [c_RW-1:0]   r_last;

  assign w_accept = in_valid && in_ready;
  // The tag reaching stage LAT means dp_x now belongs to that triple
  assign w_push   = r_tag[LAT];
  assign w_pop    = out_valid && out_ready;

  // Every accepted triple owns a FIFO slot from accept until pop; both counts
  // are registered, so out_ready never reaches in_ready combinationally.
  assign w_reserved = c_SW'(w_fifo_count) + c_SW'(r_inflight);
  assign in_ready   = r_init && (w_reserved < c_SW'(RESQ_DEPTH));

  assign out_valid = !w_empty;
  assign busy      = (r_inflight != '0) || !w_empty;
  // With the FIFO empty the last popped result stays on the output
  assign out_z     = w_empty ? r_last[c_RW-1 -: DATAW] : w_head[c_RW-1 -: DATAW];
  assign out_x     = w_empty ? r_last[2*DATAW-1:0]     : w_head[2*DATAW-1:0];

  // Operand registers: load on accept, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_a <= '0;
      dp_b <= '0;
      dp_c <= '0;
    end else if (w_accept) begin
      dp_a <= in_a;
      dp_b <= in_b;
      dp_c <= in_c;
    end
  end

  // Valid-tag shift register, in-flight count and post-reset ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init     <= 1'b0;
      r_tag      <= '0;
      r_inflight <= '0;
    end else begin
      r_init     <= 1'b1;
      r_tag      <= {r_tag[LAT-1:0], w_accept};
      r_inflight <= r_inflight + c_IFW'(w_accept) - c_IFW'(w_push);
    end
  end

  // dp_z is valid while the tag sits at stage 0; carry it alongside the tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= LAT; k++) r_zpipe[k] <= '0;
    end else begin
      r_zpipe[1] <= dp_z;
      for (int k = 2; k <= LAT; k++) r_zpipe[k] <= r_zpipe[k-1];
    end
  end

  // Remember the head as it leaves so the outputs hold when the FIFO drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_last <= '0;
    else if (w_pop) r_last <= w_head;
  end

  dp_sync_fifo #(
    .DEPTH (RESQ_DEPTH),
    .WIDTH (c_RW)
  ) u_resq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data ({r_zpipe[LAT], dp_x}),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .count     (w_fifo_count)
  );

`ifdef DP_SELF_CHECK_EN
  logic [DATAW-1:0]   w_sum;
  logic [2*DATAW-1:0] w_prod;
  logic [2*DATAW-1:0] w_xexp;
  logic [2*DATAW-1:0] r_xpipe [1:LAT];

  // Expected x from the operands currently on the datapath ports
  assign w_sum  = dp_a + dp_b;
  assign w_prod = {{DATAW{1'b0}}, dp_a} * {{DATAW{1'b0}}, dp_c};
  assign w_xexp = w_prod - {{DATAW{1'b0}}, w_sum};

  // Carry expected x with the tag, then latch any mismatch at capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= LAT; k++) r_xpipe[k] <= '0;
      chk_err <= 1'b0;
    end else begin
      r_xpipe[1] <= w_xexp;
      for (int k = 2; k <= LAT; k++) r_xpipe[k] <= r_xpipe[k-1];
      if (w_push && (dp_x != r_xpipe[LAT])) chk_err <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dp_operand_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_operand_driver
// Brief    : Scoreboard bench for dp_operand_driver with a stand-in datapath
//            (z = c[0] ? a : b, x = a*c - (a+b) through LAT registers).
// Revision : 1.0  initial release
// ============================================================================
module tb_dp_operand_driver;
  import dp_pkg::*;

  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  in_a, in_b, in_c, dp_a, dp_b, dp_c, dp_z, out_z;
  logic [15:0] dp_x, out_x;
`ifdef DP_SELF_CHECK_EN
  logic        chk_err;
`endif

  int n_pass  = 0;
  int n_total = 0;
  logic corrupt = 1'b0;
  dp_result_t exp_q[$];
  dp_result_t mon_e;

  dp_operand_driver #(.DATAW(DP_DATAW), .LAT(LAT), .RESQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
    .dp_z(dp_z), .dp_x(dp_x),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_x(out_x),
    .busy(busy)
`ifdef DP_SELF_CHECK_EN
    , .chk_err(chk_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in datapath: combinational z, x registered LAT times
  logic [15:0] xr [1:LAT];
  assign dp_z = dp_c[0] ? dp_a : dp_b;
  assign dp_x = corrupt ? 16'h0000 : xr[LAT];
  always @(posedge clk) begin
    xr[1] <= ({8'h00, dp_a} * {8'h00, dp_c}) - {8'h00, 8'(dp_a + dp_b)};
    for (int k = 2; k <= LAT; k++) xr[k] <= xr[k-1];
  end

  // Reference: expected result of one triple, straight from the arithmetic
  function automatic dp_result_t ref_model(input logic [7:0] a, b, c);
    dp_result_t r;
    int ai, bi, ci;
    ai = a; bi = b; ci = c;
    r.z = ((ci % 2) == 1) ? a : b;
    r.x = corrupt ? 16'h0000 : 16'(ai * ci - ((ai + bi) % 256));
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: each pop the DUT performs is compared with the scoreboard head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_valid_vs_model", {31'b0, out_valid}, 32'(exp_q.size() > 0));
      end else begin
        mon_e = exp_q.pop_front();
        check("out_z", {24'b0, out_z}, {24'b0, mon_e.z});
        check("out_x", {16'b0, out_x}, {16'b0, mon_e.x});
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one triple until accepted (bounded)
  task automatic issue(input logic [7:0] a, b, c);
    bit done = 0;
    in_a = a; in_b = b; in_c = c; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_model(a, b, c));
        done = 1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("issue_timeout", 32'(done), 1);
  endtask

  task automatic wait_valid(input string name);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) check(name, 32'(seen), 1);
  endtask

  task automatic pop_one();
    tick(); out_ready = 1'b1;
    tick(); out_ready = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200 && (busy || exp_q.size() != 0); i++) tick();
    check("drain_busy", {31'b0, busy}, 0);
    check("drain_queue", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int acc;
    bit dropped;
    dp_operands_t trip [6];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    #2;
    check("rst_dp_a", {24'b0, dp_a}, 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_x", {16'b0, out_x}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_first_edge", {31'b0, in_ready}, 0);
    tick();
    check("ready_after_first_edge", {31'b0, in_ready}, 1);

    // Basic triple with latency measurement
    in_a = 8'd3; in_b = 8'd4; in_c = 8'd5; in_valid = 1'b1;
    @(negedge clk);
    check("basic_in_ready", {31'b0, in_ready}, 1);
    exp_q.push_back(ref_model(8'd3, 8'd4, 8'd5));
    tick();
    in_valid = 1'b0;
    check("dp_a_loaded", {24'b0, dp_a}, 3);
    check("dp_c_loaded", {24'b0, dp_c}, 5);
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      check("latency_not_yet", {31'b0, out_valid}, 0);
    end
    @(negedge clk);
    check("latency_valid", {31'b0, out_valid}, 1);
    check("basic_out_x", {16'b0, out_x}, 32'h0008);
    check("basic_out_z", {24'b0, out_z}, 3);
    check("basic_busy", {31'b0, busy}, 1);
    pop_one();
    @(negedge clk);
    check("basic_busy_clear", {31'b0, busy}, 0);
    check("basic_empty", {31'b0, out_valid}, 0);
    check("hold_out_x", {16'b0, out_x}, 32'h0008);

    // Zero-extension case
    tick();
    issue(8'hFF, 8'h01, 8'h02);
    wait_valid("zext_timeout");
    check("zext_out_x", {16'b0, out_x}, 32'h01FE);
    check("zext_out_z", {24'b0, out_z}, 1);
`ifdef DP_SELF_CHECK_EN
    check("chk_err_clean", {31'b0, chk_err}, 0);
`endif
    pop_one();
`ifdef DP_SELF_CHECK_EN
    corrupt = 1'b1;
    issue(8'hFF, 8'h01, 8'h02);
    wait_valid("corrupt_timeout");
    corrupt = 1'b0;
    tick();
    check("chk_err_set", {31'b0, chk_err}, 1);
    pop_one();
    issue(8'h10, 8'h20, 8'h30);
    drain();
    check("chk_err_sticky", {31'b0, chk_err}, 1);
    out_ready = 1'b0;
`endif

    // Back-to-back with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_c = 8'($urandom); in_valid = 1'b1;
      @(negedge clk);
      check("b2b_in_ready", {31'b0, in_ready}, 1);
      if (in_ready) exp_q.push_back(ref_model(in_a, in_b, in_c));
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Backpressure, credit release one cycle after a single pop, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) trip[i] = dp_operands_t'({8'(i + 1), 8'($urandom), 8'($urandom)});
    acc = 0; dropped = 0;
    for (int cyc = 0; cyc < 60 && acc < 6; cyc++) begin
      in_valid  = 1'b1;
      in_a = trip[acc].a; in_b = trip[acc].b; in_c = trip[acc].c;
      out_ready = (cyc == 12) || (cyc >= 20);
      @(negedge clk);
      if (cyc == 11) check("bp_accepted_before_pop", 32'(acc), 4);
      if (cyc == 12) check("bp_full_no_ready", {31'b0, in_ready}, 0);
      if (cyc == 13) check("bp_ready_after_pop", {31'b0, in_ready}, 1);
      if (!in_ready && !dropped) begin
        dropped = 1;
        check("bp_drop_point", 32'(acc), 4);
      end
      if (in_ready) begin
        exp_q.push_back(ref_model(in_a, in_b, in_c));
        acc++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 32'(acc), 6);
    drain();

    // Randomised traffic with credit and busy checked against the scoreboard
    for (int cyc = 0; cyc < 300; cyc++) begin
      check("rand_credit", {31'b0, in_ready}, 32'(exp_q.size() < DEPTH));
      check("rand_busy", {31'b0, busy}, 32'(exp_q.size() != 0));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_a = 8'($urandom); in_b = 8'($urandom); in_c = 8'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_a, in_b, in_c));
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Asynchronous reset with three operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_c = 8'($urandom); in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) exp_q.push_back(ref_model(in_a, in_b, in_c));
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_dp_a", {24'b0, dp_a}, 0);
    check("arst_out_valid", {31'b0, out_valid}, 0);
    check("arst_out_z", {24'b0, out_z}, 0);
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_in_ready", {31'b0, in_ready}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_valid", {31'b0, out_valid}, 0);
    end
    tick();
    out_ready = 1'b0;
    issue(8'h01, 8'h01, 8'h01);
    wait_valid("post_reset_timeout");
    check("post_reset_out_x", {16'b0, out_x}, 32'hFFFF);
    check("post_reset_out_z", {24'b0, out_z}, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dp_operand_driver.md
Name: dp_operand_driver

Overview:
- Host-side front end for a generated datapath circuit: a, b, c in; combinational z out; registered x out (one SREG stage).
- Accepts signed operand triples over valid/ready and drives them onto the datapath operand ports.
- Tracks in-flight operations through the datapath register latency, then captures the aligned z/x pair into a result FIFO.
- Returns results to the host over valid/ready, in issue order.

Parameters:
- DATAW, 8, operand width; z is DATAW bits, x is 2*DATAW bits.
- LAT, 1, cycles from operands applied at dp_a/b/c to a valid dp_x (legal 1..4).
- RESQ_DEPTH, 4, result FIFO entries (power of 2, at least 2).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand triple valid.
- in_ready  out  1  driver can accept a triple.
- in_a / in_b / in_c  in  DATAW each  signed operands.
- dp_a / dp_b / dp_c  out  DATAW each  registered operands to the datapath.
- dp_z  in  DATAW  datapath z, combinational from dp_a/b/c.
- dp_x  in  2*DATAW  datapath x, registered.
- out_valid  out  1  result available.
- out_ready  in  1  host accepts result.
- out_z  out  DATAW  result z.
- out_x  out  2*DATAW  result x.
- busy  out  1  in-flight count or FIFO count is nonzero.

Behaviour:
- Reset (Rst=0, async): dp_a/b/c=0, out_valid=0, out_z=0, out_x=0, busy=0, in_ready=0. The FIFO and in-flight tracking are cleared. in_ready rises on the first Clk edge after Rst deasserts.
- Reset mid-operation: in-flight results are discarded. No out_valid until a new triple is accepted.
- Accept: an accept happens when in_valid && in_ready at a Clk edge. On accept, in_a/b/c are registered into dp_a/b/c the same edge. Without an accept, dp_* hold their value.
- Credit rule: in_ready = (fifo_count + inflight_count) < RESQ_DEPTH. A slot is reserved at accept, so an accepted result can never overflow the FIFO.
- Valid-tag shift register:
  - Stage 0 is set on accept. dp_z is sampled at stage 0, the cycle after accept, and carried along with the tag.
  - Stage LAT is reached LAT cycles after dp_* update. At that point {delayed z, dp_x} is pushed into the FIFO.
  - One accept per cycle is sustainable (throughput 1) while credit allows.
- Latency: accept at edge N → out_valid high after edge N+LAT+1 when the FIFO was empty (first-word-fall-through).
- Output: out_z/out_x show the FIFO head. A pop happens when out_valid && out_ready. Order is strictly FIFO.
- Data is stable while out_valid && !out_ready. out_z/out_x hold their last value when the FIFO is empty.
- Simultaneous push and pop: both happen, count unchanged. Credit uses the registered counts, so a pop frees a slot on the next cycle (no combinational path from out_ready to in_ready).
- Full: in_ready=0 until a pop. Empty: out_valid=0. Pointers wrap modulo RESQ_DEPTH.
- Arithmetic: the driver performs no arithmetic; data passes through bit-exact.

Optional Feature:
- Macro: DP_SELF_CHECK_EN.
- Defined:
  - Adds output port chk_err (1 bit, reset 0).
  - The driver recomputes the expected x for each accepted triple: d = (a+b) mod 2^DATAW; f = zext(a)*zext(c) mod 2^(2*DATAW); x_exp = (f − zext(d)) mod 2^(2*DATAW).
  - On FIFO push, if dp_x != x_exp, chk_err goes high and stays high until reset.
- Undefined: no port, no extra logic.

Decomposition:
- Package dp_pkg:
  - DATAW default constant.
  - typedef dp_result_t {z, x}.
  - typedef dp_operands_t {a, b, c}.
  - LAT_MAX=4 constant.
- Sub-module dp_sync_fifo: parameterised depth/width, first-word-fall-through, exposes count.
- The FSM-free tag pipeline and credit logic stay in dp_operand_driver.

Test Plan:
- Basic, with Circuit1 attached, LAT=1: a=3, b=4, c=5 accepted → one cycle with out_valid, out_x=16'h0008, out_z per the datapath mux; busy returns to 0 after the pop.
- Zero-extension case: a=8'hFF, b=1, c=2 → out_x=16'h01FE; with DP_SELF_CHECK_EN, chk_err stays 0. Forcing dp_x to 16'h0000 for that entry → chk_err=1 and sticky.
- Back-to-back: 8 triples on consecutive cycles with out_ready=1 → 8 results in issue order, and in_ready never drops.
- Backpressure: out_ready=0, issue 6 triples with RESQ_DEPTH=4 → in_ready drops after the 4th accept. Raise out_ready → remaining 2 are accepted, all 6 results arrive in order with no loss.
- Simultaneous push/pop with a full FIFO, and a pop freeing credit → count stable, in_ready reasserts exactly one cycle after the pop.
- Async reset asserted with 3 in flight → outputs 0 immediately without a clock edge. After release, no stale out_valid; a new triple a=1, b=1, c=1 → out_x=16'hFFFF.
